// File: rtl/gpio_in_filter.sv
// gpio_in_filter: per-bit synchronizer, debounce counter and edge detect.
// Define GPIO_IN_FILTER_IRQ_EN to build the sticky edge flags and irq.
module gpio_in_filter #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_W  = 8
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic [WIDTH-1:0]      pin_in,
  input  logic [DEBOUNCE_W-1:0] debounce_limit,
  output logic [WIDTH-1:0]      filt_out,
  output logic [WIDTH-1:0]      rise_evt,
  output logic [WIDTH-1:0]      fall_evt,
  output logic [WIDTH-1:0]      edge_flags,
  input  logic [WIDTH-1:0]      flag_clr,
  input  logic [WIDTH-1:0]      irq_mask,
  output logic                  irq
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0][DEBOUNCE_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]                  filt_q, filt_d;
  logic [WIDTH-1:0]                  rise_q, rise_d;
  logic [WIDTH-1:0]                  fall_q, fall_d;
  logic [WIDTH-1:0]                  s;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = pin_in;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Counter only runs while s disagrees with the accepted level.
  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (s[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= debounce_limit) begin
        filt_d[i] = s[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DEBOUNCE_W'(1);
      end
    end
    rise_d = filt_d & ~filt_q;
    fall_d = ~filt_d & filt_q;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      filt_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign filt_out = filt_q;
  assign rise_evt = rise_q;
  assign fall_evt = fall_q;

`ifdef GPIO_IN_FILTER_IRQ_EN
  logic [WIDTH-1:0] flags_q, flags_d;
  logic             irq_q, irq_d;

  // Set has priority over a same-cycle clear.
  always_comb begin
    flags_d = (flags_q & ~flag_clr) | rise_q | fall_q;
    irq_d   = |(flags_q & irq_mask);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      flags_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      irq_q   <= irq_d;
    end
  end

  assign edge_flags = flags_q;
  assign irq        = irq_q;
`else
  logic unused_irq_inputs;

  assign unused_irq_inputs = ^{flag_clr, irq_mask};
  assign edge_flags        = '0;
  assign irq               = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_in_filter.sv
// tb_gpio_in_filter: scoreboard bench with a cycle-level reference model.
// Expectations follow GPIO_IN_FILTER_IRQ_EN the same way the design does.
module tb_gpio_in_filter;

  localparam int W  = 32;
  localparam int SS = 2;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          arst;
  logic [W-1:0]  pin_in;
  logic [DW-1:0] debounce_limit;
  logic [W-1:0]  filt_out, rise_evt, fall_evt, edge_flags;
  logic [W-1:0]  flag_clr, irq_mask;
  logic          irq;

  gpio_in_filter #(
    .WIDTH(W),
    .SYNC_STAGES(SS),
    .DEBOUNCE_W(DW)
  ) dut (
    .clk(clk),
    .arst(arst),
    .pin_in(pin_in),
    .debounce_limit(debounce_limit),
    .filt_out(filt_out),
    .rise_evt(rise_evt),
    .fall_evt(fall_evt),
    .edge_flags(edge_flags),
    .flag_clr(flag_clr),
    .irq_mask(irq_mask),
    .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] filt;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] flags;
    logic         irq;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: a pin reaches the filter SS edges late; a level is
  // accepted once it has disagreed with the output for limit+1 edges.
  logic [W-1:0] hist[$];
  logic [W-1:0] m_filt, m_rise, m_fall, m_flags;
  logic         m_irq;
  logic [W-1:0] m_s, n_filt, n_flags;
  logic         n_irq;
  int           m_run[W];

  always @(posedge clk) begin
    if (arst) begin
      hist.delete();
      for (int k = 0; k < SS; k++) hist.push_back('0);
      m_filt  = '0;
      m_rise  = '0;
      m_fall  = '0;
      m_flags = '0;
      m_irq   = 1'b0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
    end else begin
      m_s = hist.pop_front();
      hist.push_back(pin_in);
      n_filt = m_filt;
      for (int i = 0; i < W; i++) begin
        if (m_s[i] != m_filt[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] > int'(debounce_limit)) begin
            n_filt[i] = m_s[i];
            m_run[i]  = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
`ifdef GPIO_IN_FILTER_IRQ_EN
      n_flags = (m_flags & ~flag_clr) | m_rise | m_fall;
      n_irq   = (m_flags & irq_mask) != '0;
`else
      n_flags = '0;
      n_irq   = 1'b0;
`endif
      m_rise  = n_filt & ~m_filt;
      m_fall  = m_filt & ~n_filt;
      m_filt  = n_filt;
      m_flags = n_flags;
      m_irq   = n_irq;
    end
    sb.push_back('{m_filt, m_rise, m_fall, m_flags, m_irq});
  end

  function automatic void chk(string name, logic [W-1:0] act,
                              logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endfunction

  exp_t e;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("filt_out", filt_out, e.filt);
      chk("rise_evt", rise_evt, e.rise);
      chk("fall_evt", fall_evt, e.fall);
      chk("edge_flags", edge_flags, e.flags);
      chk("irq", {{(W-1){1'b0}}, irq}, {{(W-1){1'b0}}, e.irq});
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    arst           = 1'b1;
    pin_in         = '1;
    debounce_limit = 8'd3;
    flag_clr       = '0;
    irq_mask       = '0;
    step(3);
    arst = 1'b0;
    step(12);

    pin_in = '0;
    step(12);
    debounce_limit = 8'd4;
    step(2);
    pin_in[0] = 1'b1;
    step(3);
    pin_in[0] = 1'b0;
    step(12);

    pin_in[5] = 1'b1;
    step(12);
    pin_in[5] = 1'b0;
    step(12);

    debounce_limit = 8'd0;
    for (int t = 0; t < 8; t++) begin
      pin_in[31] = ~pin_in[31];
      step(4);
    end
    step(6);

    debounce_limit = 8'd2;
    irq_mask[2]    = 1'b1;
    pin_in[2]      = 1'b1;
    step(10);
    pin_in[2]   = 1'b0;
    flag_clr[2] = 1'b1;
    step(8);
    flag_clr[2] = 1'b0;
    step(4);
    pin_in[2] = 1'b1;
    step(10);
    flag_clr[2] = 1'b1;
    step(1);
    flag_clr[2] = 1'b0;
    step(4);

    for (int c = 0; c < 2000; c++) begin
      if (c % 200 == 0) debounce_limit = DW'($urandom_range(0, 7));
      if (c % 300 < 150) pin_in ^= $urandom & $urandom & $urandom & $urandom;
      flag_clr = $urandom & $urandom & $urandom;
      if (c % 100 == 0) irq_mask = $urandom;
      if (c == 1000) arst = 1'b1;
      if (c == 1003) arst = 1'b0;
      step(1);
    end
    flag_clr = '0;
    step(20);

    tests++;
    if (sb.size() > 1) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d entries expected <= 1",
               sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
